// File: rtl/parity_frame_scheduler.sv
// Round-robin arbiter in front of a shared bit-serial parity engine.
// Optional expected-parity check is enabled by defining PARITY_FRAME_CHECK_EN.
module parity_frame_scheduler #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   data,
`ifdef PARITY_FRAME_CHECK_EN
    input  logic [N_REQ-1:0]         exp_par,
    output logic                     par_err,
`endif
    output logic [N_REQ-1:0]         gnt,
    output logic                     busy,
    output logic                     done,
    output logic [IDW-1:0]           done_id,
    output logic                     parity_out
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic             acc;
    logic [CW-1:0]    cnt;
    logic [IDW-1:0]   cur_id;
    logic [IDW-1:0]   last_id;
    logic [IDW-1:0]   pick;
    logic             found;
    logic             final_acc;
`ifdef PARITY_FRAME_CHECK_EN
    logic             exp_bit;
`endif

    // First requester at or above last_id+1, wrapping, so the last winner ranks lowest.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && req[(int'(last_id) + k) % N_REQ]) begin
                found = 1'b1;
                pick  = IDW'((int'(last_id) + k) % N_REQ);
            end
        end
    end

    assign final_acc = acc ^ shreg[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            done_id    <= '0;
            parity_out <= 1'b0;
            last_id    <= IDW'(N_REQ - 1);
            cur_id     <= '0;
            shreg      <= '0;
            acc        <= 1'b0;
            cnt        <= '0;
`ifdef PARITY_FRAME_CHECK_EN
            par_err    <= 1'b0;
            exp_bit    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        shreg  <= data[pick*WIDTH +: WIDTH];
                        gnt    <= ONE_HOT0 << pick;
                        cur_id <= pick;
                        acc    <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
`ifdef PARITY_FRAME_CHECK_EN
                        exp_bit <= exp_par[pick];
`endif
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc   <= final_acc;
                    shreg <= shreg >> 1;
                    cnt   <= cnt + CW'(1);
                    // Last bit is folded straight into the published result.
                    if (cnt == CW'(WIDTH - 1)) begin
                        done       <= 1'b1;
                        done_id    <= cur_id;
                        parity_out <= final_acc;
`ifdef PARITY_FRAME_CHECK_EN
                        par_err    <= (final_acc != exp_bit);
`endif
                        state      <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    gnt     <= '0;
                    busy    <= 1'b0;
                    last_id <= cur_id;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_parity_frame_scheduler.sv
// Directed bench for parity_frame_scheduler: vector table plus arbitration/reset sequences.
module tb_parity_frame_scheduler;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic [N-1:0]   exp_par;
    logic [N-1:0]   gnt;
    logic           busy;
    logic           done;
    logic [1:0]     done_id;
    logic           parity_out;
`ifdef PARITY_FRAME_CHECK_EN
    logic           par_err;
`endif

    int total = 0;
    int bad   = 0;

    parity_frame_scheduler #(.N_REQ(N), .WIDTH(W), .IDW(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .data       (data),
`ifdef PARITY_FRAME_CHECK_EN
        .exp_par    (exp_par),
        .par_err    (par_err),
`endif
        .gnt        (gnt),
        .busy       (busy),
        .done       (done),
        .done_id    (done_id),
        .parity_out (parity_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] word;
        logic       par;
        logic       ep;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One isolated transaction; data/exp_par are scrambled after the grant edge.
    task automatic run_one(input int id, input logic [7:0] word, input logic par, input logic ep);
        int n;
        @(negedge clk);
        req          = '0;
        req[id]      = 1'b1;
        data         = '0;
        data[id*W +: W] = word;
        exp_par      = '0;
        exp_par[id]  = ep;
        @(posedge clk); #1;
        chk("gnt", 32'(gnt), 32'(1 << id));
        chk("busy_hi", 32'(busy), 1);
        data    = ~data;
        exp_par = ~exp_par;
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, W);
        chk("done_id", 32'(done_id), id);
        chk("parity", 32'(parity_out), 32'(par));
        chk("gnt_in_done", 32'(gnt), 32'(1 << id));
`ifdef PARITY_FRAME_CHECK_EN
        chk("par_err", 32'(par_err), 32'(par != ep));
`endif
        req = '0;
        @(posedge clk); #1;
        chk("busy_lo", 32'(busy), 0);
        chk("done_lo", 32'(done), 0);
        chk("gnt_lo", 32'(gnt), 0);
        chk("id_hold", 32'(done_id), id);
        chk("par_hold", 32'(parity_out), 32'(par));
    endtask

    // Hold req with the given pattern, dropping a requester only if drop=1.
    task automatic run_rr(input string nm, input logic [N-1:0] r, input int o0, input int o1,
                          input int o2, input int o3, input logic drop);
        int order[4];
        int k;
        int cyc;
        int last;
        order = '{o0, o1, o2, o3};
        k = 0;
        cyc = 0;
        last = 0;
        @(negedge clk);
        req  = r;
        data = {8'h44, 8'h33, 8'h22, 8'h11};
        while (k < 4 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                chk({nm, "_id"}, 32'(done_id), order[k]);
                if (k > 0) chk({nm, "_gap"}, cyc - last, W + 2);
                last = cyc;
                if (drop) req[order[k]] = 1'b0;
                k++;
            end
        end
        chk({nm, "_count"}, k, 4);
        req = '0;
    endtask

    initial begin
        int ndone;
        vecs = '{
            '{0, 8'hB5, 1'b1, 1'b1},
            '{1, 8'h00, 1'b0, 1'b0},
            '{1, 8'hFF, 1'b0, 1'b1},
            '{1, 8'h01, 1'b1, 1'b1},
            '{2, 8'h6C, 1'b0, 1'b0},
            '{3, 8'h80, 1'b1, 1'b0},
            '{3, 8'h7F, 1'b1, 1'b1},
            '{2, 8'h03, 1'b0, 1'b1}
        };
        reset   = 1'b1;
        req     = '0;
        data    = '0;
        exp_par = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_done_id", 32'(done_id), 0);
        chk("rst_parity", 32'(parity_out), 0);
`ifdef PARITY_FRAME_CHECK_EN
        chk("rst_par_err", 32'(par_err), 0);
`endif
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++)
            run_one(vecs[i].id, vecs[i].word, vecs[i].par, vecs[i].ep);
        run_one(2, 8'h03, 1'b0, 1'b0);

        do_reset();
        run_rr("fair", 4'b1111, 0, 1, 2, 3, 1'b1);

        do_reset();
        run_rr("starve", 4'b0011, 0, 1, 0, 1, 1'b0);

        // Reset lands on the 4th SHIFT edge: transaction aborts silently.
        do_reset();
        @(negedge clk);
        req  = 4'b0001;
        data = 32'h0000_00FF;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_busy", 32'(busy), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_gnt", 32'(gnt), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        reset = 1'b0;
        req   = '0;
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("mid_rst_no_done", ndone, 0);
        run_one(0, 8'h80, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
